// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming 2x2 max-pool block.
// Optional build macro: POOL_AVG_EN (adds average pooling; widens the
// partial-result path by two bits so a four-sample sum cannot overflow).
// The sample width follows WID_PE_BITS; a 16-bit default is supplied
// when the surrounding build does not define it.

`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

package pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pool_state_e;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam int DATA_W_DEF   = `WID_PE_BITS;
    localparam int MAX_COLS_DEF = 256;

    // Width of the pair register, line buffer and internal pooling math.
`ifdef POOL_AVG_EN
    localparam int BUF_W = DATA_W_DEF + 2;
`else
    localparam int BUF_W = DATA_W_DEF;
`endif

    // Signed maximum; on a tie either operand is the same value.
    function automatic logic signed [BUF_W-1:0] smax(
        input logic signed [BUF_W-1:0] a,
        input logic signed [BUF_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for the 2x2 pool: one entry per output column.
// Single port, one read or one write per cycle. Even input rows write
// their horizontal partial result, odd rows read it back. The read
// address is registered and the data is driven combinationally from it,
// so a read launched on the even-column beat is ready for the odd beat.

module pool_line_buf #(
    parameter int DEPTH = 128,
    parameter int W     = 16,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] addr_reg;

    // Write port and registered read address; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            addr_reg <= addr;
        end
    end

    assign rdata = mem[addr_reg];

endmodule

// File: rtl/pool_max_stream.sv
// Streaming 2x2 / stride-2 pooling stage fed by the NL output stream.
// Samples arrive row-major, one per accepted beat. Even columns park in
// a pair register, odd columns fold into a horizontal partial, even rows
// store that partial in the line buffer and odd rows combine it with the
// current partial to emit one pooled sample, one cycle after the beat.
// Bypass (pool_enable=0 at start) forwards every sample with latency 1.
// Optional build macro: POOL_AVG_EN (pool_mode=1 selects floor average).
// rst is synchronous and active low.

module pool_max_stream
    import pool_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int CNT_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pool_enable,
    input  logic              pool_mode,
    input  logic [CNT_W-1:0]  cfg_cols,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] COLS_MAX = CNT_W'(MAX_COLS);

    pool_state_e state_reg, state_next;

    logic [CNT_W-1:0]        col_reg, row_reg;
    logic [CNT_W-1:0]        cols_reg, rows_reg;
    logic                    pool_en_reg;
    logic signed [BUF_W-1:0] pair_reg;
    logic                    out_valid_reg;
    logic [DATA_W-1:0]       out_data_reg;
    logic                    done_reg;
    logic                    err_cfg_reg;

    logic                    accept;
    logic                    out_take;
    logic                    last_col;
    logic                    last_beat;
    logic                    cfg_ok;
    logic                    avg_sel;
    logic signed [BUF_W-1:0] in_ext;
    logic signed [BUF_W-1:0] pair_m;
    logic signed [BUF_W-1:0] pooled;
    logic [BUF_W-1:0]        lb_rdata;
    logic                    lb_we;
    logic                    lb_re;
    logic [LB_AW-1:0]        lb_addr;

`ifdef POOL_AVG_EN
    pool_mode_e mode_reg;
    logic       unused_pooled_hi;
    assign avg_sel          = (mode_reg == POOL_AVG);
    assign unused_pooled_hi = ^pooled[BUF_W-1:DATA_W];
`else
    logic unused_mode;
    assign avg_sel     = 1'b0;
    assign unused_mode = pool_mode;
`endif

    assign in_ready  = (state_reg == RUN) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_take  = out_valid_reg && out_ready;
    assign last_col  = (col_reg == cols_reg - ONE);
    assign last_beat = last_col && (row_reg == rows_reg - ONE);
    assign in_ext    = BUF_W'(signed'(in_data));

    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign done      = done_reg;
    assign err_cfg   = err_cfg_reg;

    // Line buffer slot is the output column; even rows write on the odd
    // beat, odd rows launch the read on the even beat of the same pair.
    assign lb_addr = col_reg[LB_AW:1];
    assign lb_we   = accept && pool_en_reg &&  col_reg[0] && !row_reg[0];
    assign lb_re   = accept && pool_en_reg && !col_reg[0] &&  row_reg[0];

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .W     (BUF_W),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .re    (lb_re),
        .addr  (lb_addr),
        .wdata (pair_m),
        .rdata (lb_rdata)
    );

    // Configuration legality: pooling needs even dims that fit the buffer.
    always_comb begin
        cfg_ok = 1'b0;
        if (pool_enable) begin
            cfg_ok = !cfg_cols[0] && (cfg_cols >= TWO) && (cfg_cols <= COLS_MAX)
                  && !cfg_rows[0] && (cfg_rows >= TWO);
        end else begin
            cfg_ok = (cfg_cols != '0) && (cfg_rows != '0);
        end
    end

    // Horizontal partial and final 2x2 result for the current beat.
    always_comb begin
        pair_m = avg_sel ? (pair_reg + in_ext) : smax(pair_reg, in_ext);
        pooled = avg_sel ? ((signed'(lb_rdata) + pair_m) >>> 2)
                         : smax(signed'(lb_rdata), pair_m);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: run until the last beat, then drain the final output.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start && cfg_ok) state_next = RUN;
            RUN:     if (accept && last_beat) state_next = FLUSH;
            FLUSH:   if (out_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Config latch, frame counters, pair register and output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            cols_reg      <= '0;
            rows_reg      <= '0;
            pool_en_reg   <= 1'b0;
            pair_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
            err_cfg_reg   <= 1'b0;
`ifdef POOL_AVG_EN
            mode_reg      <= POOL_MAX;
`endif
        end else begin
            done_reg <= 1'b0;

            if (state_reg == IDLE && start) begin
                if (cfg_ok) begin
                    cols_reg    <= cfg_cols;
                    rows_reg    <= cfg_rows;
                    pool_en_reg <= pool_enable;
                    col_reg     <= '0;
                    row_reg     <= '0;
                    err_cfg_reg <= 1'b0;
`ifdef POOL_AVG_EN
                    mode_reg    <= pool_mode_e'(pool_mode);
`endif
                end else begin
                    err_cfg_reg <= 1'b1;
                end
            end

            if (out_take) begin
                out_valid_reg <= 1'b0;
            end

            if (accept) begin
                if (last_col) begin
                    col_reg <= '0;
                    row_reg <= last_beat ? '0 : row_reg + ONE;
                end else begin
                    col_reg <= col_reg + ONE;
                end

                if (!pool_en_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= in_data;
                end else if (!col_reg[0]) begin
                    pair_reg <= in_ext;
                end else if (row_reg[0]) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= pooled[DATA_W-1:0];
                end
            end

            if (state_reg == FLUSH && out_take) begin
                done_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pool_max_stream.sv
// Self-checking bench for pool_max_stream. A frame-level model derives
// the expected pooled stream from the whole input frame; one monitor
// process checks handshakes, latency, hold stability and done on every
// cycle. Directed frames pin the model with hand-computed literals.
// Build macro POOL_AVG_EN adds the average-pooling case.

`timescale 1ns/1ps

module tb_pool_max_stream;

    localparam int DW = pool_pkg::DATA_W_DEF;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pool_enable;
    logic          pool_mode;
    logic [CW-1:0] cfg_cols;
    logic [CW-1:0] cfg_rows;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err_cfg;

    pool_max_stream #(
        .DATA_W   (DW),
        .MAX_COLS (256),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pool_enable (pool_enable),
        .pool_mode   (pool_mode),
        .cfg_cols    (cfg_cols),
        .cfg_rows    (cfg_rows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int frame[$];
    int exp_q[$];
    int obs_q[$];

    bit mon_pool  = 1'b1;
    int mon_cols  = 1;
    int mon_total = 0;
    int beat      = 0;
    int blocked   = 0;
    int bp_mode   = 0;
    bit gaps      = 1'b0;
    int stall_cnt = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pooled stream computed from the complete frame.
    task automatic build_expected(input bit pool, input bit avg, input int cols, input int rows);
        exp_q.delete();
        if (!pool) begin
            foreach (frame[i]) exp_q.push_back(frame[i]);
        end else begin
            for (int r = 0; r < rows; r += 2) begin
                for (int c = 0; c < cols; c += 2) begin
                    int a, b, d, e, m;
                    a = frame[r*cols + c];
                    b = frame[r*cols + c + 1];
                    d = frame[(r+1)*cols + c];
                    e = frame[(r+1)*cols + c + 1];
                    if (avg) begin
                        exp_q.push_back((a + b + d + e) >>> 2);
                    end else begin
                        m = a;
                        if (b > m) m = b;
                        if (d > m) m = d;
                        if (e > m) m = e;
                        exp_q.push_back(m);
                    end
                end
            end
        end
    endtask

    task automatic rand_frame(input int n);
        frame.delete();
        for (int i = 0; i < n; i++)
            frame.push_back(int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1)));
    endtask

    task automatic do_start(input bit pool, input int cols, input int rows);
        pool_enable = pool;
        cfg_cols    = CW'(cols);
        cfg_rows    = CW'(rows);
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic feed(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int waited;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = DW'(frame[i]);
            waited   = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                waited++;
                if (waited > 2000) begin
                    chk("in_ready_timeout", 0, 1);
                    break;
                end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            waited++;
            if (waited > 5000) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        chk("busy_after_done", busy, 0);
        chk("outputs_left", exp_q.size(), 0);
        step();
    endtask

    task automatic run_frame(input bit pool, input bit avg, input int cols, input int rows);
        mon_pool  = pool;
        mon_cols  = cols;
        mon_total = cols * rows;
        beat      = 0;
        blocked   = 0;
        obs_q.delete();
        build_expected(pool, avg, cols, rows);
        do_start(pool, cols, rows);
        feed(cols * rows);
        wait_done();
    endtask

    // Downstream ready: always, 5-cycle stall per output, or random.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: begin
                if (out_valid && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                    stall_cnt = 0;
                end
            end
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Compare process: every cycle against the frame model.
    bit pending    = 1'b0;
    bit prev_stall = 1'b0;
    bit done_pend  = 1'b0;
    int prev_data  = 0;

    always @(negedge clk) begin
        int sdata;
        sdata = int'($signed(out_data));
        if (!rst) begin
            exp_q.delete();
            pending    = 1'b0;
            prev_stall = 1'b0;
            done_pend  = 1'b0;
        end else begin
            chk("out_valid", out_valid, pending || prev_stall);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
                else                   chk("out_data", sdata, exp_q[0]);
            end
            if (prev_stall) chk("hold_data", sdata, prev_data);
            if (out_valid && !out_ready) chk("in_ready_blocked", in_ready, 0);
            if (in_valid && !in_ready && out_valid && !out_ready) blocked++;
            chk("done", done, done_pend);
            done_pend = 1'b0;

            if (out_valid && out_ready) begin
                obs_q.push_back(sdata);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_q.size() == 0 && beat == mon_total) done_pend = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = sdata;

            pending = 1'b0;
            if (in_valid && in_ready) begin
                int r, c;
                r = beat / mon_cols;
                c = beat % mon_cols;
                pending = !mon_pool || ((r % 2 == 1) && (c % 2 == 1));
                beat++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        pool_enable = 1'b1;
        pool_mode   = 1'b0;
        cfg_cols    = '0;
        cfg_rows    = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;

        // Reset state.
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cfg", err_cfg, 0);
        chk("rst_in_ready", in_ready, 0);
        step();
        rst = 1'b1;
        step();

        // Basic max: 4x2.
        frame = '{1, 5, -3, 2, 4, 0, 7, -8};
        run_frame(1'b1, 1'b0, 4, 2);
        $display("basic max: %0d outputs", obs_q.size());
        chk("basic_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("basic_out0", obs_q[0], 5);
            chk("basic_out1", obs_q[1], 7);
        end

        // All negative: signed compare.
        frame = '{-1, -2, -3, -4};
        run_frame(1'b1, 1'b0, 2, 2);
        $display("all negative: %0d outputs", obs_q.size());
        chk("neg_count", obs_q.size(), 1);
        if (obs_q.size() == 1) chk("neg_out0", obs_q[0], -1);

        // Backpressure: 5-cycle stall on every output.
        bp_mode = 1;
        rand_frame(16);
        run_frame(1'b1, 1'b0, 4, 4);
        $display("backpressure: %0d outputs, %0d blocked cycles", obs_q.size(), blocked);
        chk("bp_count", obs_q.size(), 4);
        chk("bp_in_ready_dropped", (blocked > 0), 1);
        bp_mode = 0;

        // Bad configurations: {pool, cols, rows}.
        begin
            int bad[5][3];
            bad = '{'{1, 3, 2}, '{1, 0, 2}, '{1, 258, 2}, '{1, 4, 3}, '{0, 0, 1}};
            for (int k = 0; k < 5; k++) begin
                do_start(bad[k][0] != 0, bad[k][1], bad[k][2]);
                @(negedge clk);
                $display("bad cfg pool=%0d cols=%0d rows=%0d: err_cfg=%0d busy=%0d",
                         bad[k][0], bad[k][1], bad[k][2], err_cfg, busy);
                chk("bad_err_cfg", err_cfg, 1);
                chk("bad_busy", busy, 0);
                step();
            end
        end
        frame = '{3, -9, 12, 12};
        run_frame(1'b1, 1'b0, 2, 2);
        $display("valid start after bad cfg: err_cfg=%0d", err_cfg);
        chk("err_cleared", err_cfg, 0);
        if (obs_q.size() == 1) chk("after_err_out0", obs_q[0], 12);

        // Bypass 3x1.
        frame = '{9, -2, 4};
        run_frame(1'b0, 1'b0, 3, 1);
        $display("bypass: %0d outputs", obs_q.size());
        chk("byp_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("byp_out0", obs_q[0], 9);
            chk("byp_out1", obs_q[1], -2);
            chk("byp_out2", obs_q[2], 4);
        end

        // Random frames with input gaps and random downstream ready.
        gaps    = 1'b1;
        bp_mode = 2;
        for (int k = 0; k < 6; k++) begin
            int cols, rows;
            cols = 2 * $urandom_range(1, 8);
            rows = 2 * $urandom_range(1, 3);
            rand_frame(cols * rows);
            run_frame(1'b1, 1'b0, cols, rows);
            $display("random pool %0dx%0d: %0d outputs", cols, rows, obs_q.size());
            chk("rand_count", obs_q.size(), (cols / 2) * (rows / 2));
        end
        begin
            int cols, rows;
            cols = $urandom_range(1, 7);
            rows = $urandom_range(1, 3);
            rand_frame(cols * rows);
            run_frame(1'b0, 1'b0, cols, rows);
            $display("random bypass %0dx%0d: %0d outputs", cols, rows, obs_q.size());
            chk("rand_byp_count", obs_q.size(), cols * rows);
        end
        gaps    = 1'b0;
        bp_mode = 0;

        // Reset mid-frame: abort, no done.
        rand_frame(16);
        mon_pool  = 1'b1;
        mon_cols  = 4;
        mon_total = 16;
        beat      = 0;
        build_expected(1'b1, 1'b0, 4, 4);
        do_start(1'b1, 4, 4);
        feed(6);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        $display("mid-frame reset: out_valid=%0d busy=%0d", out_valid, busy);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        repeat (4) step();

        // Widest frame: MAX_COLS x 2.
        rand_frame(512);
        run_frame(1'b1, 1'b0, 256, 2);
        $display("max width: %0d outputs", obs_q.size());
        chk("maxw_count", obs_q.size(), 128);

`ifdef POOL_AVG_EN
        // Average pooling: floor((1+2+3-7)/4) = -1.
        pool_mode = 1'b1;
        frame = '{1, 2, 3, -7};
        run_frame(1'b1, 1'b1, 2, 2);
        $display("avg: %0d outputs", obs_q.size());
        chk("avg_count", obs_q.size(), 1);
        if (obs_q.size() == 1) chk("avg_out0", obs_q[0], -1);
        pool_mode = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
